// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control blocks: FSM encoding,
// architectural constants and the default MULT/DIV latency.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_e;

  // Register $0 is hard-wired to zero, so it never creates a true dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DEF_MULDIV_CYCLES = 8;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualifying edges, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core. Drives the PC,
// IF/ID and ID/EX enables for load-use stalls, taken-branch flushes and
// multi-cycle MULT/DIV occupancy of EX, and counts stalls and flushes.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = DEF_MULDIV_CYCLES,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_muldiv_start,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MD_W = $clog2(MULDIV_CYCLES) + 1;

  state_e          state;
  logic [MD_W-1:0] md_left;
  logic            load_use;
  logic            md_start;
  logic            flush_evt;

  // A load in ID/EX whose destination feeds the instruction in IF/ID cannot
  // be forwarded in time; $0 is excluded because it is never really written.
  assign load_use = idex_mem_read && (idex_rt != REG_ZERO) &&
                    ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

  // Prioritised Mealy decode of the pipeline enables from state and inputs.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    muldiv_busy  = 1'b0;
    md_start     = 1'b0;
    flush_evt    = 1'b0;

    if (!rst_n) begin
      // Hold the front end and inject NOPs while the core is in reset.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (state == MD_BUSY) begin
      // EX is frozen, so branch and load-use inputs are stale and ignored.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ex_hold     = 1'b1;
      muldiv_busy = 1'b1;
    end else if (ex_branch_taken) begin
      // Squash the wrong-path instructions; a coincident MULT/DIV start or
      // load-use stall belongs to an instruction that is being discarded.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_evt    = 1'b1;
    end else if (ex_muldiv_start) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ex_hold     = 1'b1;
      md_start    = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // MULT/DIV occupancy FSM: the start cycle plus MULDIV_CYCLES-1 busy cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: reset abandons any MULT/DIV in flight; the counter is cleared too.
      state   <= RUN;
      md_left <= '0;
    end else begin
      case (state)
        RUN: begin
          if (md_start) begin
            state   <= MD_BUSY;
            md_left <= MD_W'(MULDIV_CYCLES - 2);
          end
        end
        MD_BUSY: begin
          if (md_left == '0) begin
            state <= RUN;
          end else begin
            md_left <= md_left - 1'b1;
          end
        end
        default: begin
          state   <= RUN;
          md_left <= '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_write),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_evt),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table-driven single-cycle vectors
// through a scoreboard queue, plus hand-written multi-cycle sequences.
module tb_hazard_ctrl;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_hold;
    logic muldiv_busy;
  } outs_t;

  typedef struct packed {
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       idex_mem_read;
    logic [4:0] idex_rt;
    logic       ex_branch_taken;
    logic       ex_muldiv_start;
  } ins_t;

  typedef struct packed {
    ins_t  ins;
    outs_t exp;
  } vec_t;

  localparam outs_t O_RUN   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam outs_t O_LU    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam outs_t O_BR    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam outs_t O_MDST  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam outs_t O_MDB   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam outs_t O_RST   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ins_t  I_IDLE  = '0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_n_sat = 1'b0;
  logic [4:0]  id_rs, id_rt, idex_rt;
  logic        id_uses_rt, idex_mem_read, ex_branch_taken, ex_muldiv_start;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, muldiv_busy;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_ex_hold, s_muldiv_busy;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  outs_t sb_q[$];
  vec_t  vecs[11];

  always #5 clk = ~clk;

  hazard_ctrl #(.MULDIV_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ex_branch_taken(ex_branch_taken), .ex_muldiv_start(ex_muldiv_start),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold), .muldiv_busy(muldiv_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter instance for saturation, with its own reset.
  hazard_ctrl #(.MULDIV_CYCLES(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n_sat),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ex_branch_taken(ex_branch_taken), .ex_muldiv_start(ex_muldiv_start),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
    .id_ex_bubble(s_id_ex_bubble), .ex_hold(s_ex_hold), .muldiv_busy(s_muldiv_busy),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  function automatic outs_t dut_outs();
    return '{pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, muldiv_busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input ins_t i);
    id_rs           = i.id_rs;
    id_rt           = i.id_rt;
    id_uses_rt      = i.id_uses_rt;
    idex_mem_read   = i.idex_mem_read;
    idex_rt         = i.idex_rt;
    ex_branch_taken = i.ex_branch_taken;
    ex_muldiv_start = i.ex_muldiv_start;
  endtask

  // Called just after a rising edge: drive, score at the falling edge, then
  // advance past the next rising edge so the counters have taken this cycle.
  task automatic apply(input string name, input ins_t i, input outs_t exp, input logic flush_evt);
    outs_t e;
    drive(i);
    sb_q.push_back(exp);
    if (!exp.pc_write) exp_stall++;
    if (flush_evt) exp_flush++;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check({name, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(name, 32'(dut_outs()), 32'(e));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string name);
    check({name, " stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    check({name, " flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t t;
    drive(I_IDLE);

    // ---- Reset state
    #2;
    check("reset outputs", 32'(dut_outs()), 32'(O_RST));
    check("reset stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset flush_cnt", 32'(flush_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rst_n_sat = 1'b1;

    // ---- Single-cycle vectors: {rs, rt, uses_rt, mem_read, idex_rt, br, md}
    vecs[0]  = '{'{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0}, O_RUN};  // idle
    vecs[1]  = '{'{5'd1, 5'd0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0}, O_LU};   // rs load-use
    vecs[2]  = '{'{5'd1, 5'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0}, O_RUN};  // load gone
    vecs[3]  = '{'{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}, O_RUN};  // $0 target
    vecs[4]  = '{'{5'd3, 5'd6, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0}, O_RUN};  // rt unused
    vecs[5]  = '{'{5'd3, 5'd6, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0}, O_LU};   // rt used
    vecs[6]  = '{'{5'd9, 5'd4, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0}, O_RUN};  // no match
    vecs[7]  = '{'{5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0}, O_BR};   // branch+lu
    vecs[8]  = '{'{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1}, O_BR};   // branch+md
    vecs[9]  = '{'{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0}, O_RUN};  // no MD_BUSY
    vecs[10] = '{'{5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0}, O_BR};   // branch
    for (int i = 0; i < 11; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].ins, vecs[i].exp, vecs[i].exp.if_id_flush);
    end
    check_counters("after table");
    check("table stall total", 32'(exp_stall), 32'd2);
    check("table flush total", 32'(exp_flush), 32'd3);

    // ---- MULT/DIV: 8 hold cycles, busy on 2..8, branch mid-busy ignored
    t = I_IDLE; t.ex_muldiv_start = 1'b1;
    apply("md cycle1", t, O_MDST, 1'b0);
    for (int c = 2; c <= 8; c++) begin
      t = I_IDLE;
      if (c == 4) t.ex_branch_taken = 1'b1;
      apply($sformatf("md cycle%0d", c), t, O_MDB, 1'b0);
    end
    apply("md cycle9", I_IDLE, O_RUN, 1'b0);
    check_counters("after md");

    // ---- MULT/DIV then load-use evaluated normally back in RUN
    t = I_IDLE; t.ex_muldiv_start = 1'b1;
    apply("md2 start", t, O_MDST, 1'b0);
    for (int c = 2; c <= 8; c++) begin
      t = I_IDLE; t.idex_mem_read = 1'b1; t.idex_rt = 5'd8; t.id_rs = 5'd8;
      apply($sformatf("md2 busy%0d", c), t, O_MDB, 1'b0);
    end
    apply("md2 lu in run", t, O_LU, 1'b0);
    apply("md2 idle", I_IDLE, O_RUN, 1'b0);
    check_counters("after md2");

    // ---- Reset mid-MD_BUSY at busy cycle 3
    t = I_IDLE; t.ex_muldiv_start = 1'b1;
    apply("mdr start", t, O_MDST, 1'b0);
    apply("mdr busy1", I_IDLE, O_MDB, 1'b0);
    apply("mdr busy2", I_IDLE, O_MDB, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid-md reset outputs", 32'(dut_outs()), 32'(O_RST));
    check("mid-md reset stall_cnt", 32'(stall_cnt), 32'd0);
    check("mid-md reset flush_cnt", 32'(flush_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
    apply("after reset release", I_IDLE, O_RUN, 1'b0);
    check_counters("after reset release");

    // ---- Load-use then release: stall_cnt = 1
    t = I_IDLE; t.idex_mem_read = 1'b1; t.idex_rt = 5'd1; t.id_rs = 5'd1;
    apply("lu stall", t, O_LU, 1'b0);
    t.idex_mem_read = 1'b0;
    apply("lu release", t, O_RUN, 1'b0);
    check("lu stall_cnt", 32'(stall_cnt), 32'd1);

    // ---- Saturation on the 4-bit instance while load_use held 20 cycles
    rst_n_sat = 1'b0;
    #1;
    check("sat reset", 32'(s_stall_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n_sat = 1'b1;
    t = I_IDLE; t.idex_mem_read = 1'b1; t.idex_rt = 5'd12; t.id_rt = 5'd12; t.id_uses_rt = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      apply($sformatf("sat hold%0d", c), t, O_LU, 1'b0);
      if (c == 14) check("sat stall_cnt at 14", 32'(s_stall_cnt), 32'd14);
    end
    check("sat stall_cnt capped", 32'(s_stall_cnt), 32'hF);
    apply("sat release", I_IDLE, O_RUN, 1'b0);
    check("sat stall_cnt stays", 32'(s_stall_cnt), 32'hF);
    check_counters("wide counters after sat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
